axis_ramp_source: RTL and testbench

AXI-Stream transmitter that produces finite frames of a byte-ramp test pattern on a master stream port. It drives the slave side of the byte-wise stream processors in the PL data path, such as the pixel inverter, from the PL side. The ramp is deterministic, so a downstream checker can predict every output byte. The block also reports frame completion to control logic.

---
 rtl/axis_ramp_source.sv | 125 ++++++++++++
 tb/tb_axis_ramp_source.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/axis_ramp_source.sv
`timescale 1ns/1ps
// axis_ramp_source: AXI-Stream master that emits finite frames of a byte ramp.
// Byte i of each beat is (base + i) mod 256, and base advances by the number
// of bytes per beat after every accepted beat. This lets a downstream checker
// predict every byte from the seed alone. Completed frames are counted, and
// each completion is flagged with a one-cycle done pulse.
module axis_ramp_source #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  axi_clk,
  input  logic                  axi_rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic [7:0]            seed,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  frame_count,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_last
);

  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state, state_next;
  logic [LEN_WIDTH-1:0]  remaining, remaining_next;
  logic [7:0]            base, base_next;
  logic                  valid_next;
  logic [DATA_WIDTH-1:0] data_next;
  logic                  last_next;
  logic                  done_next;
  logic [LEN_WIDTH-1:0]  count_next;
  logic                  handshake;

  // Build one beat of the ramp starting at byte value b (byte 0 in the LSBs).
  function automatic logic [DATA_WIDTH-1:0] ramp(input logic [7:0] b);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < BYTES; i++) begin
      r[i*8 +: 8] = b + 8'(i);
    end
    return r;
  endfunction

  assign handshake = m_axis_valid & m_axis_ready;

  // State and all outputs are flops; reset abandons any frame in progress.
  always_ff @(posedge axi_clk or negedge axi_rst) begin
    if (!axi_rst) begin
      state        <= IDLE;
      remaining    <= '0;
      base         <= '0;
      m_axis_valid <= 1'b0;
      m_axis_data  <= '0;
      m_axis_last  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      frame_count  <= '0;
    end else begin
      state        <= state_next;
      remaining    <= remaining_next;
      base         <= base_next;
      m_axis_valid <= valid_next;
      m_axis_data  <= data_next;
      m_axis_last  <= last_next;
      busy         <= (state_next == SEND);
      done         <= done_next;
      frame_count  <= count_next;
    end
  end

  // Next-state logic: accept a non-empty frame in IDLE, step the ramp on
  // each handshake in SEND, and close the frame after the last beat.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    base_next      = base;
    valid_next     = m_axis_valid;
    data_next      = m_axis_data;
    last_next      = m_axis_last;
    done_next      = 1'b0;
    count_next     = frame_count;

    case (state)
      IDLE: begin
        if (start && (frame_len != '0)) begin
          state_next     = SEND;
          remaining_next = frame_len;
          base_next      = seed;
          valid_next     = 1'b1;
          data_next      = ramp(seed);
          last_next      = (frame_len == LEN_WIDTH'(1));
        end
      end
      SEND: begin
        if (handshake) begin
          if (remaining == LEN_WIDTH'(1)) begin
            state_next     = IDLE;
            remaining_next = '0;
            valid_next     = 1'b0;
            last_next      = 1'b0;
            done_next      = 1'b1;
            count_next     = frame_count + LEN_WIDTH'(1);
          end else begin
            remaining_next = remaining - LEN_WIDTH'(1);
            base_next      = base + 8'(BYTES);
            data_next      = ramp(base + 8'(BYTES));
            last_next      = (remaining == LEN_WIDTH'(2));
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axis_ramp_source.sv
`timescale 1ns/1ps
// tb_axis_ramp_source: directed vectors with hand-computed beats for the
// ramp source (32-bit data, 16-bit lengths). Inputs change and outputs are
// observed on the falling edge, half a cycle away from the sampling edge.
module tb_axis_ramp_source;

  logic        axi_clk;
  logic        axi_rst;
  logic        start;
  logic [15:0] frame_len;
  logic [7:0]  seed;
  logic        busy;
  logic        done;
  logic [15:0] frame_count;
  logic        m_axis_valid;
  logic        m_axis_ready;
  logic [31:0] m_axis_data;
  logic        m_axis_last;

  int checks;
  int failures;

  axis_ramp_source #(
    .DATA_WIDTH(32),
    .LEN_WIDTH (16)
  ) dut (
    .axi_clk     (axi_clk),
    .axi_rst     (axi_rst),
    .start       (start),
    .frame_len   (frame_len),
    .seed        (seed),
    .busy        (busy),
    .done        (done),
    .frame_count (frame_count),
    .m_axis_valid(m_axis_valid),
    .m_axis_ready(m_axis_ready),
    .m_axis_data (m_axis_data),
    .m_axis_last (m_axis_last)
  );

  // 10 ns free-running clock.
  initial begin
    axi_clk = 1'b0;
    forever #5 axi_clk = ~axi_clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive inputs for the next rising edge, then wait to the falling edge after it.
  task automatic applyStimulus(input logic s, input logic [15:0] len,
                               input logic [7:0] sd, input logic rdy);
    start        = s;
    frame_len    = len;
    seed         = sd;
    m_axis_ready = rdy;
    @(negedge axi_clk);
  endtask

  task automatic checkBeat(input string tag, input logic [31:0] data,
                           input logic last);
    checkOutput({tag, "_valid"}, 64'(m_axis_valid), 64'(1));
    checkOutput({tag, "_data"},  64'(m_axis_data),  64'(data));
    checkOutput({tag, "_last"},  64'(m_axis_last),  64'(last));
  endtask

  task automatic checkDone(input string tag, input logic [15:0] count);
    checkOutput({tag, "_valid"}, 64'(m_axis_valid), 64'(0));
    checkOutput({tag, "_last"},  64'(m_axis_last),  64'(0));
    checkOutput({tag, "_busy"},  64'(busy),         64'(0));
    checkOutput({tag, "_done"},  64'(done),         64'(1));
    checkOutput({tag, "_count"}, 64'(frame_count),  64'(count));
  endtask

  // Directed sequence: reset, basic frame, byte wrap, backpressure,
  // ignored starts, back-to-back start, and reset mid-frame.
  initial begin
    checks       = 0;
    failures     = 0;
    axi_rst      = 1'b0;
    start        = 1'b0;
    frame_len    = '0;
    seed         = '0;
    m_axis_ready = 1'b1;

    @(negedge axi_clk);
    @(negedge axi_clk);
    checkOutput("rst_valid", 64'(m_axis_valid), 64'(0));
    checkOutput("rst_data",  64'(m_axis_data),  64'(0));
    checkOutput("rst_last",  64'(m_axis_last),  64'(0));
    checkOutput("rst_busy",  64'(busy),         64'(0));
    checkOutput("rst_done",  64'(done),         64'(0));
    checkOutput("rst_count", 64'(frame_count),  64'(0));
    axi_rst = 1'b1;
    @(negedge axi_clk);

    // Basic frame: seed 0x10, three beats.
    applyStimulus(1'b1, 16'd3, 8'h10, 1'b1);
    checkOutput("basic_busy", 64'(busy), 64'(1));
    checkBeat("basic_b0", 32'h13121110, 1'b0);
    applyStimulus(1'b0, 16'd0, 8'h00, 1'b1);
    checkBeat("basic_b1", 32'h17161514, 1'b0);
    applyStimulus(1'b0, 16'd0, 8'h00, 1'b1);
    checkBeat("basic_b2", 32'h1B1A1918, 1'b1);
    applyStimulus(1'b0, 16'd0, 8'h00, 1'b1);
    checkDone("basic_end", 16'd1);
    applyStimulus(1'b0, 16'd0, 8'h00, 1'b1);
    checkOutput("basic_done_pulse", 64'(done), 64'(0));

    // Byte wrap: seed 0xFE, two beats.
    applyStimulus(1'b1, 16'd2, 8'hFE, 1'b1);
    checkBeat("wrap_b0", 32'h0100FFFE, 1'b0);
    applyStimulus(1'b0, 16'd0, 8'h00, 1'b1);
    checkBeat("wrap_b1", 32'h05040302, 1'b1);
    applyStimulus(1'b0, 16'd0, 8'h00, 1'b1);
    checkDone("wrap_end", 16'd2);

    // Backpressure: ready low for the first three cycles of beat 0.
    applyStimulus(1'b1, 16'd2, 8'h00, 1'b0);
    checkBeat("bp_stall0", 32'h03020100, 1'b0);
    applyStimulus(1'b0, 16'd0, 8'h00, 1'b0);
    checkBeat("bp_stall1", 32'h03020100, 1'b0);
    applyStimulus(1'b0, 16'd0, 8'h00, 1'b0);
    checkBeat("bp_stall2", 32'h03020100, 1'b0);
    applyStimulus(1'b0, 16'd0, 8'h00, 1'b1);
    checkBeat("bp_b1", 32'h07060504, 1'b1);
    applyStimulus(1'b0, 16'd0, 8'h00, 1'b1);
    checkDone("bp_end", 16'd3);

    // Zero-length start is ignored.
    applyStimulus(1'b1, 16'd0, 8'h55, 1'b1);
    checkOutput("zero_valid", 64'(m_axis_valid), 64'(0));
    checkOutput("zero_busy",  64'(busy),         64'(0));
    applyStimulus(1'b0, 16'd0, 8'h00, 1'b1);
    checkOutput("zero_done",  64'(done),         64'(0));
    checkOutput("zero_count", 64'(frame_count),  64'(3));

    // Start pulsed mid-frame is ignored; start in the done cycle is accepted.
    applyStimulus(1'b1, 16'd3, 8'h20, 1'b1);
    checkBeat("mid_b0", 32'h23222120, 1'b0);
    applyStimulus(1'b1, 16'd5, 8'h80, 1'b1);
    checkBeat("mid_b1", 32'h27262524, 1'b0);
    applyStimulus(1'b0, 16'd0, 8'h00, 1'b1);
    checkBeat("mid_b2", 32'h2B2A2928, 1'b1);
    applyStimulus(1'b0, 16'd0, 8'h00, 1'b1);
    checkDone("mid_end", 16'd4);
    applyStimulus(1'b1, 16'd2, 8'h40, 1'b1);
    checkBeat("b2b_b0", 32'h43424140, 1'b0);
    applyStimulus(1'b0, 16'd0, 8'h00, 1'b1);
    checkBeat("b2b_b1", 32'h47464544, 1'b1);
    applyStimulus(1'b0, 16'd0, 8'h00, 1'b1);
    checkDone("b2b_end", 16'd5);

    // Reset mid-frame: outputs clear at once, frame is abandoned.
    applyStimulus(1'b1, 16'd4, 8'h60, 1'b1);
    checkBeat("rstmid_b0", 32'h63626160, 1'b0);
    applyStimulus(1'b0, 16'd0, 8'h00, 1'b1);
    checkBeat("rstmid_b1", 32'h67666564, 1'b0);
    axi_rst = 1'b0;
    #1;
    checkOutput("rstmid_valid", 64'(m_axis_valid), 64'(0));
    checkOutput("rstmid_data",  64'(m_axis_data),  64'(0));
    checkOutput("rstmid_last",  64'(m_axis_last),  64'(0));
    checkOutput("rstmid_busy",  64'(busy),         64'(0));
    checkOutput("rstmid_done",  64'(done),         64'(0));
    checkOutput("rstmid_count", 64'(frame_count),  64'(0));
    @(negedge axi_clk);
    axi_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 16'd0, 8'h00, 1'b1);
      checkOutput("post_rst_valid", 64'(m_axis_valid), 64'(0));
      checkOutput("post_rst_done",  64'(done),         64'(0));
      checkOutput("post_rst_busy",  64'(busy),         64'(0));
    end
    applyStimulus(1'b1, 16'd1, 8'hAA, 1'b1);
    checkBeat("single_b0", 32'hADACABAA, 1'b1);
    applyStimulus(1'b0, 16'd0, 8'h00, 1'b1);
    checkDone("single_end", 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
